pc_sequencer: RTL and testbench

- Program-counter controller for the single-cycle core.
- Owns the PC register and runs the Start/Done program handshake with the test harness.
- Sequences instruction fetch and resolves branches: forwards the instruction's branch pointer to the branch-target lookup table and loads the returned absolute target.
- Keeps cycle and retired-instruction counters for per-program performance reporting.

---
 rtl/pc_sequencer.sv | 102 ++++++++++
 tb/tb_pc_sequencer.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// Program-counter controller: owns the PC, runs the Start/Done handshake,
// resolves branches through the external target lookup table and keeps perf counters.
//
// state | meaning
// IDLE  | after reset, waiting for Start; PC and counters hold
// RUN   | program executing; one instruction per non-stalled cycle
// DONE  | program ended by halt or PC overrun; Done high until next Start
module pc_sequencer #(
  parameter int PC_W     = 10,
  parameter int LUT_AW   = 5,
  parameter int START_PC = 0,
  parameter int CNT_W    = 16
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              Start,
  input  logic [PC_W-1:0]   StartAddr,
  input  logic              Stall,
  input  logic              BranchReq,
  input  logic              BranchCond,
  input  logic [LUT_AW-1:0] BranchPtr,
  output logic [LUT_AW-1:0] LutAddr,
  input  logic [PC_W-1:0]   LutTarget,
  input  logic              HaltReq,
  output logic [PC_W-1:0]   ProgCtr,
  output logic              FetchEn,
  output logic              Busy,
  output logic              Done,
  output logic              Overrun,
  output logic [CNT_W-1:0]  CycleCnt,
  output logic [CNT_W-1:0]  InstCnt
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [PC_W-1:0]  PC_RST  = PC_W'(START_PC);
  localparam logic [PC_W-1:0]  PC_MAX  = '1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t state;

  // The lookup table is combinational, so a branch resolves in the same cycle.
  assign LutAddr = BranchPtr;
  assign FetchEn = Busy && !Stall;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state    <= S_IDLE;
      ProgCtr  <= PC_RST;
      Busy     <= 1'b0;
      Done     <= 1'b0;
      Overrun  <= 1'b0;
      CycleCnt <= '0;
      InstCnt  <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (Start) begin
            state    <= S_RUN;
            ProgCtr  <= StartAddr;
            Busy     <= 1'b1;
            Done     <= 1'b0;
            Overrun  <= 1'b0;
            CycleCnt <= '0;
            InstCnt  <= '0;
          end
        end
        S_RUN: begin
          if (CycleCnt != CNT_MAX) CycleCnt <= CycleCnt + CNT_W'(1);
          if (!Stall) begin
            if (InstCnt != CNT_MAX) InstCnt <= InstCnt + CNT_W'(1);
            if (HaltReq) begin
              state <= S_DONE;
              Busy  <= 1'b0;
              Done  <= 1'b1;
            end else if (BranchReq && BranchCond) begin
              ProgCtr <= LutTarget;
            end else if (ProgCtr == PC_MAX) begin
              // No wrap: the last instruction retires, then the program is aborted.
              Overrun <= 1'b1;
              state   <= S_DONE;
              Busy    <= 1'b0;
              Done    <= 1'b1;
            end else begin
              ProgCtr <= ProgCtr + PC_W'(1);
            end
          end
        end
        default: begin
          state <= S_IDLE;
          Busy  <= 1'b0;
          Done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed scenarios plus random stimulus, all checked
// every cycle against a behavioural program-execution model.
module tb_pc_sequencer;
  localparam int PC_W   = 10;
  localparam int LUT_AW = 5;
  localparam int CNT_W  = 8;
  localparam int PCMAX  = (1 << PC_W) - 1;
  localparam int CMAX   = (1 << CNT_W) - 1;

  logic              Clk = 1'b0;
  logic              Reset_n = 1'b1;
  logic              Start = 1'b0;
  logic [PC_W-1:0]   StartAddr = '0;
  logic              Stall = 1'b0;
  logic              BranchReq = 1'b0;
  logic              BranchCond = 1'b0;
  logic [LUT_AW-1:0] BranchPtr = '0;
  logic [LUT_AW-1:0] LutAddr;
  logic [PC_W-1:0]   LutTarget;
  logic              HaltReq = 1'b0;
  logic [PC_W-1:0]   ProgCtr;
  logic              FetchEn, Busy, Done, Overrun;
  logic [CNT_W-1:0]  CycleCnt, InstCnt;

  logic [PC_W-1:0] lut [32];
  assign LutTarget = lut[LutAddr];

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  pc_sequencer #(.PC_W(PC_W), .LUT_AW(LUT_AW), .START_PC(0), .CNT_W(CNT_W)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .Start(Start), .StartAddr(StartAddr),
    .Stall(Stall), .BranchReq(BranchReq), .BranchCond(BranchCond),
    .BranchPtr(BranchPtr), .LutAddr(LutAddr), .LutTarget(LutTarget),
    .HaltReq(HaltReq), .ProgCtr(ProgCtr), .FetchEn(FetchEn), .Busy(Busy),
    .Done(Done), .Overrun(Overrun), .CycleCnt(CycleCnt), .InstCnt(InstCnt)
  );

  always #5 Clk = ~Clk;

  // Behavioural model: a program is either running or not; each non-stalled
  // running cycle retires one instruction and picks the next PC.
  bit m_run = 0, m_done = 0, m_ovr = 0;
  int m_pc = 0, m_cyc = 0, m_inst = 0;

  always @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      m_run = 0; m_done = 0; m_ovr = 0; m_pc = 0; m_cyc = 0; m_inst = 0;
    end else if (!m_run) begin
      if (Start) begin
        m_run = 1; m_done = 0; m_ovr = 0; m_pc = int'(StartAddr); m_cyc = 0; m_inst = 0;
      end
    end else begin
      m_cyc = (m_cyc < CMAX) ? m_cyc + 1 : CMAX;
      if (!Stall) begin
        m_inst = (m_inst < CMAX) ? m_inst + 1 : CMAX;
        if (HaltReq) begin
          m_run = 0; m_done = 1;
        end else if (BranchReq && BranchCond) begin
          m_pc = int'(lut[BranchPtr]);
        end else if (m_pc == PCMAX) begin
          m_run = 0; m_done = 1; m_ovr = 1;
        end else begin
          m_pc = m_pc + 1;
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge Clk) begin
    if (chk_en) begin
      check("ProgCtr",  32'(ProgCtr),  32'(m_pc));
      check("Busy",     32'(Busy),     32'(m_run));
      check("Done",     32'(Done),     32'(m_done));
      check("Overrun",  32'(Overrun),  32'(m_ovr));
      check("CycleCnt", 32'(CycleCnt), 32'(m_cyc));
      check("InstCnt",  32'(InstCnt),  32'(m_inst));
      check("FetchEn",  32'(FetchEn),  32'(m_run && !Stall));
      check("LutAddr",  32'(LutAddr),  32'(BranchPtr));
    end
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge Clk);
      #1;
    end
  endtask

  task automatic clear_inputs();
    Start = 0; Stall = 0; BranchReq = 0; BranchCond = 0; BranchPtr = '0; HaltReq = 0;
  endtask

  task automatic start_prog(input logic [PC_W-1:0] a);
    Start = 1; StartAddr = a;
    step();
    Start = 0;
  endtask

  task automatic halt_prog();
    HaltReq = 1;
    step();
    HaltReq = 0;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) lut[i] = PC_W'($urandom);
    lut[1] = 10'h020;
    lut[2] = 10'h200;

    #2 Reset_n = 0;
    #20 Reset_n = 1;
    chk_en = 1;
    #1;
    check("rst_pc", 32'(ProgCtr), 32'h0);
    check("rst_busy", 32'(Busy), 32'h0);
    step(2);

    // Straight-line program of 5 instructions plus halt.
    start_prog(10'h000);
    check("seq_pc0", 32'(ProgCtr), 32'h0);
    step(5);
    check("seq_pc5", 32'(ProgCtr), 32'h5);
    halt_prog();
    check("seq_done", 32'(Done), 32'h1);
    check("seq_inst", 32'(InstCnt), 32'd6);
    check("seq_cyc", 32'(CycleCnt), 32'd6);
    check("seq_busy", 32'(Busy), 32'h0);

    // Taken and not-taken branch at 0x010.
    start_prog(10'h010);
    BranchReq = 1; BranchCond = 1; BranchPtr = 5'd1;
    #1 check("br_lutaddr", 32'(LutAddr), 32'h1);
    step();
    clear_inputs();
    check("br_taken", 32'(ProgCtr), 32'h020);
    halt_prog();
    start_prog(10'h010);
    BranchReq = 1; BranchCond = 0; BranchPtr = 5'd1;
    step();
    clear_inputs();
    check("br_nottaken", 32'(ProgCtr), 32'h011);
    halt_prog();

    // Three stall cycles at 0x007.
    start_prog(10'h007);
    Stall = 1;
    step(3);
    check("stall_pc", 32'(ProgCtr), 32'h007);
    check("stall_cyc", 32'(CycleCnt), 32'd3);
    check("stall_inst", 32'(InstCnt), 32'd0);
    Stall = 0;
    step();
    check("stall_resume", 32'(ProgCtr), 32'h008);
    halt_prog();

    // Sequential run off the top of the address space.
    start_prog(10'h3FE);
    check("ovr_pc0", 32'(ProgCtr), 32'h3FE);
    step();
    check("ovr_pc1", 32'(ProgCtr), 32'h3FF);
    step();
    check("ovr_flag", 32'(Overrun), 32'h1);
    check("ovr_done", 32'(Done), 32'h1);
    check("ovr_pchold", 32'(ProgCtr), 32'h3FF);
    check("ovr_inst", 32'(InstCnt), 32'd2);
    start_prog(10'h100);
    check("ovr_clear", 32'(Overrun), 32'h0);
    halt_prog();

    // Halt beats a simultaneous taken branch; Start ignored while running.
    start_prog(10'h040);
    HaltReq = 1; BranchReq = 1; BranchCond = 1; BranchPtr = 5'd1;
    step();
    clear_inputs();
    check("halt_wins_pc", 32'(ProgCtr), 32'h040);
    check("halt_wins_done", 32'(Done), 32'h1);
    start_prog(10'h050);
    Start = 1; StartAddr = 10'h123;
    step();
    Start = 0;
    check("start_ignored", 32'(ProgCtr), 32'h051);
    halt_prog();

    // Self-loop branch long enough to saturate both counters.
    start_prog(10'h200);
    BranchReq = 1; BranchCond = 1; BranchPtr = 5'd2;
    step(300);
    clear_inputs();
    check("sat_pc", 32'(ProgCtr), 32'h200);
    check("sat_inst", 32'(InstCnt), 32'(CMAX));
    check("sat_cyc", 32'(CycleCnt), 32'(CMAX));
    halt_prog();

    // Asynchronous reset in the middle of a program.
    start_prog(10'h020);
    step(5);
    check("mid_pc", 32'(ProgCtr), 32'h025);
    #2 Reset_n = 0;
    #1;
    check("arst_pc", 32'(ProgCtr), 32'h0);
    check("arst_busy", 32'(Busy), 32'h0);
    check("arst_done", 32'(Done), 32'h0);
    check("arst_cyc", 32'(CycleCnt), 32'h0);
    check("arst_inst", 32'(InstCnt), 32'h0);
    Reset_n = 1;
    step(2);

    // Random programs.
    for (int c = 0; c < 3000; c++) begin
      Start      = m_run ? ($urandom_range(0, 9) == 0) : ($urandom_range(0, 2) == 0);
      StartAddr  = ($urandom_range(0, 3) == 0) ? PC_W'(10'h3F0 + $urandom_range(0, 15))
                                               : PC_W'($urandom);
      Stall      = ($urandom_range(0, 4) == 0);
      HaltReq    = ($urandom_range(0, 24) == 0);
      BranchReq  = ($urandom_range(0, 2) == 0);
      BranchCond = $urandom_range(0, 1) == 1;
      BranchPtr  = LUT_AW'($urandom);
      if ($urandom_range(0, 499) == 0) begin
        #2 Reset_n = 0;
        #1 Reset_n = 1;
      end
      step();
    end
    clear_inputs();
    step(2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
